sram_port_arbiter: RTL

- Shares one unified memory request port between the instruction-fetch requester (inst side) and the load/store requester (data side) of the MIPS core.
- Sits between the fetch stage / memory stage and the bus bridge.
- Allows one outstanding transaction at a time.
- Data side has fixed priority over inst side.
- Routes each response back to the requester that issued it, and drops responses for cancelled fetches.

---
 rtl/sram_arb_pkg.sv | 38 +++
 rtl/sram_port_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/sram_arb_pkg.sv
// ----------------------------------------------------------------------------
// sram_arb_pkg
//   Shared types and constants for the instruction/data SRAM port arbiter.
//   - arb_state_t : arbiter FSM states
//   - mem_cmd_t   : latched bus command {wen, addr, wdata}
//   - WEN_READ    : byte-enable value that marks a read
// ----------------------------------------------------------------------------
package sram_arb_pkg;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;

    localparam logic [3:0] WEN_READ = 4'b0000;

    typedef enum logic [2:0] {
        IDLE,
        REQ_I,
        REQ_D,
        WAIT_I,
        WAIT_D
    } arb_state_t;

    typedef struct packed {
        logic [3:0]            wen;
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] wdata;
    } mem_cmd_t;

    // A read command for an instruction fetch: no byte enables, no store data.
    function automatic mem_cmd_t fetch_cmd(input logic [ARB_ADDR_W-1:0] addr);
        mem_cmd_t c;
        c.wen   = WEN_READ;
        c.addr  = addr;
        c.wdata = '0;
        return c;
    endfunction

endpackage

// File: rtl/sram_port_arbiter.sv
// ----------------------------------------------------------------------------
// sram_port_arbiter
//   Shares one memory request port between the instruction-fetch side and
//   the load/store side. One outstanding transaction at a time, data side has
//   fixed priority, responses are routed back to the issuing side, and
//   responses for cancelled fetches are swallowed.
//
//   Optional feature (macro SRAM_ARB_STARVE_GUARD_EN): after STARVE_LIMIT
//   consecutive data grants made while a fetch is waiting, the fetch is
//   granted once even if data_req is high.
//
//   Ports:
//     clk, resetn                   clock, async active-low reset
//     inst_req/addr/cancel          fetch request side
//     inst_valid/rdata              fetch response (one-cycle pulse)
//     data_req/wen/addr/wdata       load/store request side
//     data_valid/rdata              load/store response (one-cycle pulse)
//     mem_req/wen/addr/wdata        registered bus request, held to mem_ready
//     mem_ready, mem_rvalid, rdata  bus handshake and response
// ----------------------------------------------------------------------------
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_cancel,
    output logic              inst_valid,
    output logic [DATA_W-1:0] inst_rdata,

    input  logic              data_req,
    input  logic [3:0]        data_wen,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_valid,
    output logic [DATA_W-1:0] data_rdata,

    output logic              mem_req,
    output logic [3:0]        mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    // The latched command uses the package struct, so widths must agree.
    generate
        if (ADDR_W != ARB_ADDR_W || DATA_W != ARB_DATA_W || STARVE_LIMIT < 1) begin : g_param_check
            $error("sram_port_arbiter: unsupported parameter combination");
        end
    endgenerate

    arb_state_t state_q, state_d;
    mem_cmd_t   cmd_q,   cmd_d;
    logic       mem_req_q, mem_req_d;
    logic       drop_q,    drop_d;

    logic       grant_d;
    logic       grant_i;
    logic       force_i;

`ifdef SRAM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(STARVE_LIMIT);

    logic [CNT_W-1:0] starve_q, starve_d;

    // Fetch jumps the queue once data has won STARVE_LIMIT times in a row.
    assign force_i = inst_req && (starve_q == CNT_LIMIT);

    always_comb begin
        starve_d = starve_q;
        if (state_q == IDLE && !inst_req) begin
            starve_d = '0;
        end else if (grant_i) begin
            starve_d = '0;
        end else if (grant_d && inst_req && starve_q != CNT_LIMIT) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign force_i = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State register (plus the registered bus-side outputs)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            cmd_q     <= '0;
            mem_req_q <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            mem_req_q <= mem_req_d;
            drop_q    <= drop_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        grant_d = (state_q == IDLE) && data_req && !force_i;
        grant_i = (state_q == IDLE) && inst_req && !grant_d;

        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (grant_d) begin
                    state_d = REQ_D;
                end else if (grant_i) begin
                    state_d = REQ_I;
                end
            end
            REQ_I:   if (mem_ready)  state_d = WAIT_I;
            REQ_D:   if (mem_ready)  state_d = WAIT_D;
            WAIT_I:  if (mem_rvalid) state_d = IDLE;
            WAIT_D:  if (mem_rvalid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        cmd_d = cmd_q;
        if (grant_d) begin
            cmd_d.wen   = data_wen;
            cmd_d.addr  = data_addr;
            cmd_d.wdata = data_wdata;
        end else if (grant_i) begin
            cmd_d = fetch_cmd(inst_addr);
        end

        // mem_req rises the cycle after the grant and falls after acceptance.
        mem_req_d = mem_req_q;
        if (grant_d || grant_i) begin
            mem_req_d = 1'b1;
        end else if ((state_q == REQ_I || state_q == REQ_D) && mem_ready) begin
            mem_req_d = 1'b0;
        end

        // A cancelled fetch still completes on the bus; only its response
        // is swallowed. The flag lives until the arbiter returns to IDLE.
        drop_d = 1'b0;
        unique case (state_q)
            IDLE:    drop_d = grant_i && inst_cancel;
            REQ_I:   drop_d = drop_q || inst_cancel;
            WAIT_I:  drop_d = mem_rvalid ? 1'b0 : (drop_q || inst_cancel);
            default: drop_d = 1'b0;
        endcase

        // A cancel arriving together with the response also swallows it.
        inst_valid = (state_q == WAIT_I) && mem_rvalid && !drop_q && !inst_cancel;
        data_valid = (state_q == WAIT_D) && mem_rvalid;

        // Gate read data so the outputs never carry X while idle.
        inst_rdata = inst_valid ? mem_rdata : '0;
        data_rdata = data_valid ? mem_rdata : '0;
    end

    assign mem_req   = mem_req_q;
    assign mem_wen   = cmd_q.wen;
    assign mem_addr  = cmd_q.addr;
    assign mem_wdata = cmd_q.wdata;

endmodule
